// File: rtl/pc_unit.sv
// pc_unit: architectural program counter for the single-cycle MIPS core.
// Selects the next PC from sequential, branch, jump, jump-register and
// exception sources. Also provides a stall input, a trap for misaligned
// jump-register targets, a one-cycle redirect pulse for flush logic and a
// saturating count of PC updates.
module pc_unit #(
  parameter int              WIDTH        = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic [1:0]       pc_sel,
  input  logic             branch_taken,
  input  logic [15:0]      branch_offset,
  input  logic [25:0]      jump_target,
  input  logic [WIDTH-1:0] jr_addr,
  input  logic             exc_req,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             redirect,
  output logic             misalign_err,
  output logic [CNT_W-1:0] adv_count
);

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  logic [WIDTH-1:0] br_off;
  logic [WIDTH-1:0] br_tgt;
  logic [WIDTH-1:0] jmp_tgt;
  logic [WIDTH-1:0] pc_nxt;
  logic             redir_nxt;
  logic             mis_nxt;
  logic             upd;

  // Sequential successor; wraps silently modulo 2^WIDTH.
  assign pc_plus4 = pc + WIDTH'(4);

  // Branch target: word offset, sign-extended, scaled to bytes.
  assign br_off = {{(WIDTH-16){branch_offset[15]}}, branch_offset} << 2;
  assign br_tgt = pc_plus4 + br_off;

  // J-type target keeps the region bits above bit 27 of pc+4. At the minimum
  // width there are no region bits, so the field alone forms the address.
  if (WIDTH > 28) begin : g_jmp_region
    assign jmp_tgt = {pc_plus4[WIDTH-1:28], jump_target, 2'b00};
  end else begin : g_jmp_flat
    assign jmp_tgt = {jump_target, 2'b00};
  end

  // Prioritised next-PC selection: exception beats stall beats control flow.
  always_comb begin
    pc_nxt    = pc;
    redir_nxt = 1'b0;
    mis_nxt   = 1'b0;
    upd       = 1'b0;
    if (exc_req) begin
      pc_nxt    = EXC_VECTOR;
      redir_nxt = 1'b1;
      upd       = 1'b1;
    end else if (!en) begin
      pc_nxt = pc;
    end else begin
      upd = 1'b1;
      unique case (pc_sel)
        SEL_JR: begin
          redir_nxt = 1'b1;
          if (jr_addr[1:0] != 2'b00) begin
            pc_nxt  = EXC_VECTOR;
            mis_nxt = 1'b1;
          end else begin
            pc_nxt = jr_addr;
          end
        end
        SEL_JMP: begin
          pc_nxt    = jmp_tgt;
          redir_nxt = 1'b1;
        end
        SEL_BR: begin
          if (branch_taken) begin
            pc_nxt    = br_tgt;
            redir_nxt = 1'b1;
          end else begin
            pc_nxt = pc_plus4;
          end
        end
        SEL_SEQ: pc_nxt = pc_plus4;
        default: pc_nxt = pc_plus4;
      endcase
    end
  end

  // PC and status pulses; reset forces the vector immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc           <= RESET_VECTOR;
      redirect     <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      pc           <= pc_nxt;
      redirect     <= redir_nxt;
      misalign_err <= mis_nxt;
    end
  end

  // Count PC updates, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      adv_count <= '0;
    end else if (upd && (adv_count != {CNT_W{1'b1}})) begin
      adv_count <= adv_count + CNT_W'(1);
    end
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the single-cycle MIPS core; successor to the plain PC register.
- Holds the architectural PC and computes the next PC internally from the control inputs: sequential, conditional branch, J-type jump, jump-register, and exception redirect.
- Adds stall (enable), a misaligned-target trap, a redirect pulse for downstream flush logic, and a saturating advance counter.
- Drives the instruction-memory address directly.

Parameters:
- WIDTH, 32, PC/address width in bits; legal range 28 to 64.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned.
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception or misaligned jump-register; must be word-aligned.
- CNT_W, 16, width of the advance counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- en  in  1  1 = PC may advance this cycle; 0 = stall (hold).
- pc_sel  in  2  next-PC source: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- branch_taken  in  1  branch condition result; only used when pc_sel=01.
- branch_offset  in  16  raw I-type immediate in words, signed.
- jump_target  in  26  raw J-type target field.
- jr_addr  in  WIDTH  register-file value for jump-register.
- exc_req  in  1  exception request; highest priority after reset.
- pc  out  WIDTH  current PC, registered.
- pc_plus4  out  WIDTH  pc+4, combinational, modulo 2^WIDTH.
- redirect  out  1  registered; 1 for the cycle after any non-sequential PC load.
- misalign_err  out  1  registered; 1 for the cycle after a misaligned jump-register trap.
- adv_count  out  CNT_W  registered count of PC updates since reset; saturates.

Behaviour:
- Reset (reset_n=0, asynchronous, no clock needed):
  - pc=RESET_VECTOR, redirect=0, misalign_err=0, adv_count=0.
  - Outputs hold these values while reset_n=0.
  - Reset asserted mid-operation overrides everything immediately.
  - First update occurs on the first rising edge after reset_n rises.
- Arithmetic: all additions are modulo 2^WIDTH; wrap-around is silent and is not an error.
- Candidate next-PC values:
  - seq = pc_plus4.
  - br = pc_plus4 + (sign_extend(branch_offset) << 2).
  - jmp = {pc_plus4[WIDTH-1:28], jump_target, 2'b00}.
  - jr = jr_addr.
- Next-PC selection, evaluated at each rising edge, first match wins:
  1. exc_req=1: pc<=EXC_VECTOR, redirect<=1, misalign_err<=0. This applies even when en=0; an exception overrides a stall.
  2. en=0: pc holds, redirect<=0, misalign_err<=0, adv_count holds.
  3. pc_sel=11 and jr_addr[1:0]!=0: pc<=EXC_VECTOR, redirect<=1, misalign_err<=1.
  4. pc_sel=11: pc<=jr, redirect<=1.
  5. pc_sel=10: pc<=jmp, redirect<=1.
  6. pc_sel=01 and branch_taken=1: pc<=br, redirect<=1.
  7. Otherwise (pc_sel=00, or pc_sel=01 with branch_taken=0): pc<=seq, redirect<=0.
- redirect and misalign_err are single-cycle pulses unless the triggering condition repeats on consecutive edges.
- adv_count increments on every edge where pc is updated (cases 1 and 3–7). It holds at 2^CNT_W-1 once reached; no wrap.
- A branch whose target equals pc_plus4 still asserts redirect (taken is what matters).
- pc[1:0] is always 00, provided the vector parameters are aligned.
- Latency: the PC change is visible one clock after the inputs are sampled; pc_plus4 follows pc combinationally.

Test Plan:
- Reset release, en=1, pc_sel=00, 3 clocks -> pc 0x0, 0x4, 0x8, 0xC; adv_count=3; redirect stays 0.
- pc=0x100, pc_sel=01, branch_taken=1, branch_offset=16'hFFFC -> pc=0x0F4, redirect=1 for one cycle. Same inputs with branch_taken=0 -> pc=0x104, redirect=0.
- pc=0x4000_0010, pc_sel=10, jump_target=26'h000_0040 -> pc=0x4000_0100. Then pc_sel=11, jr_addr=0x2000_0000 -> pc=0x2000_0000.
- pc_sel=11, jr_addr=0x0000_0102 -> pc=0x180, misalign_err=1 and redirect=1 for one cycle, then both 0.
- en=0 for 4 clocks at pc=0x20 -> pc and adv_count frozen. Then exc_req=1 while en=0 -> pc=0x180.
- Wrap and reset: pc=0xFFFF_FFFC, seq -> pc=0x0. Assert reset_n=0 mid-cycle -> pc=0x0 and adv_count=0 before the next edge. CNT_W=2 run of 5 updates -> adv_count saturates at 3.
